// File: rtl/tri_bus_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tri_pkg : state encoding and clog2 helper shared by the tri-state bus arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package tri_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tri_bus_arbiter_rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_pick : combinational round-robin picker, search starts at ptr+1 and wraps
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_pick
  import tri_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  int            idx;
  logic [IW-1:0] idx_w;

  // The previous owner (ptr) is visited last, so it only wins when alone.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      idx_w = IW'(idx);
      if (!gnt_any && req[idx_w]) begin
        gnt_any = 1'b1;
        gnt_idx = idx_w;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tri_bus_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tri_bus_arbiter : round-robin owner sequencer for a shared tri-state line
// Rev 1.0
// ----------------------------------------------------------------------------
module tri_bus_arbiter
  import tri_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  parameter  int TURN_CYC = 1,
  localparam int IW       = clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  ena,
  output logic [IW-1:0] owner,
  output logic          owner_vld,
  output logic          timeout
);

  localparam int            HW          = (clog2(MAX_HOLD) < 1) ? 1 : clog2(MAX_HOLD);
  localparam int            TW          = clog2(TURN_CYC) + 1;
  localparam logic [HW-1:0] C_HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] C_TURN_LAST = TW'(TURN_CYC - 1);
  localparam logic [IW-1:0] C_PTR_RST   = IW'(N - 1);

  state_t        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] turn_cnt_q, turn_cnt_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [N-1:0]  ena_q, ena_d;
  logic          owner_vld_q, owner_vld_d;
  logic          timeout_q, timeout_d;

  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          own_req;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  assign own_req = req[owner_q];

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    turn_cnt_d  = turn_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    ena_d       = ena_q;
    owner_vld_d = owner_vld_q;
    timeout_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d          = ST_GRANT;
          ena_d            = '0;
          ena_d[pick_idx]  = 1'b1;
          owner_d          = pick_idx;
          owner_vld_d      = 1'b1;
          hold_cnt_d       = '0;
        end
      end

      ST_GRANT: begin
        // Voluntary drop and hold expiry share one release path; only expiry pulses timeout.
        if (!own_req || (hold_cnt_q == C_HOLD_LAST)) begin
          state_d     = ST_TURN;
          ena_d       = '0;
          owner_d     = '0;
          owner_vld_d = 1'b0;
          rr_ptr_d    = owner_q;
          turn_cnt_d  = '0;
          timeout_d   = own_req;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end

      ST_TURN: begin
        if (turn_cnt_q == C_TURN_LAST) begin
          if (pick_any) begin
            state_d          = ST_GRANT;
            ena_d            = '0;
            ena_d[pick_idx]  = 1'b1;
            owner_d          = pick_idx;
            owner_vld_d      = 1'b1;
            hold_cnt_d       = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          turn_cnt_d = turn_cnt_q + TW'(1);
        end
      end

      default: begin
        state_d     = ST_IDLE;
        ena_d       = '0;
        owner_d     = '0;
        owner_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      turn_cnt_q  <= '0;
      rr_ptr_q    <= C_PTR_RST;
      owner_q     <= '0;
      ena_q       <= '0;
      owner_vld_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      turn_cnt_q  <= turn_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      ena_q       <= ena_d;
      owner_vld_q <= owner_vld_d;
      timeout_q   <= timeout_d;
    end
  end

  assign ena       = ena_q;
  assign owner     = owner_q;
  assign owner_vld = owner_vld_q;
  assign timeout   = timeout_q;

  a_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ena_q));
  a_vld    : assert property (@(posedge clk) disable iff (!rst_n) owner_vld_q == (|ena_q));
  a_owner  : assert property (@(posedge clk) disable iff (!rst_n) ena_q[owner_q] == owner_vld_q);
  // A new enable pattern may only appear out of an all-low cycle.
  a_gap    : assert property (@(posedge clk) disable iff (!rst_n)
                              ((ena_q != '0) && ($past(ena_q) != ena_q)) |-> ($past(ena_q) == '0));

endmodule
`default_nettype wire

// File: tb/tb_tri_bus_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tri_bus_arbiter : scoreboard bench, expected grants queued by stimulus
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_tri_bus_arbiter;
  import tri_pkg::*;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int TURN_CYC = 1;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '0;
  logic [N-1:0] ena;
  logic [1:0]   owner;
  logic         owner_vld;
  logic         timeout;

  always #5 clk = ~clk;

  tri_bus_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD),
    .TURN_CYC (TURN_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .ena       (ena),
    .owner     (owner),
    .owner_vld (owner_vld),
    .timeout   (timeout)
  );

  // Shared line: each driver contributes its sin only while its enable is high.
  logic [7:0] sin [N];
  logic [7:0] drv [N];
  logic [7:0] line_val;
  int         line_drivers;

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign sin[g] = 8'((g + 1) * 17);
    assign drv[g] = ena[g] ? sin[g] : 8'h00;
  end

  always_comb begin
    line_val     = '0;
    line_drivers = 0;
    for (int i = 0; i < N; i++) begin
      if (ena[i]) begin
        line_val     = line_val | drv[i];
        line_drivers = line_drivers + 1;
      end
    end
  end

  typedef struct packed {
    logic [1:0] own;
    logic [7:0] len;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic expect_grant(input logic [1:0] o, input int l, input logic t);
    exp_t e;
    e.own = o;
    e.len = 8'(l);
    e.to  = t;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [N-1:0] r, input int n);
    req = r;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ena", 32'(ena), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_owner_vld", 32'(owner_vld), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    rst_n = 1'b1;
  endtask

  // Monitor: rebuilds each grant from the enables and checks it against the queue.
  initial begin
    logic         in_grant;
    logic         had_grant;
    logic [1:0]   cur_own;
    int           cur_len;
    int           zero_run;
    logic [N-1:0] prev_ena;
    exp_t         e;
    in_grant  = 1'b0;
    had_grant = 1'b0;
    cur_own   = '0;
    cur_len   = 0;
    zero_run  = 0;
    prev_ena  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_grant  = 1'b0;
        had_grant = 1'b0;
        zero_run  = 0;
      end else begin
        chk("line_drivers", 32'(line_drivers), owner_vld ? 32'd1 : 32'd0);
        if (owner_vld) chk("line_value", 32'(line_val), 32'(sin[owner]));
        if (ena != '0) begin
          if (!in_grant) begin
            if (had_grant) chk("turn_gap", 32'(zero_run >= TURN_CYC), 32'd1);
            chk("grant_onehot", 32'(ena), 32'(1) << owner);
            in_grant = 1'b1;
            cur_own  = owner;
            cur_len  = 1;
          end else begin
            chk("steady_ena", 32'(ena), 32'(prev_ena));
            cur_len++;
          end
          chk("timeout_in_grant", 32'(timeout), 32'h0);
          zero_run = 0;
        end else begin
          if (in_grant) begin
            in_grant  = 1'b0;
            had_grant = 1'b1;
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_grant: actual owner %0d len %0d required none", cur_own, cur_len);
            end else begin
              e = exp_q.pop_front();
              chk("grant_owner", 32'(cur_own), 32'(e.own));
              chk("grant_len", 32'(cur_len), 32'(e.len));
              chk("grant_timeout", 32'(timeout), 32'(e.to));
            end
          end else begin
            chk("timeout_quiet", 32'(timeout), 32'h0);
          end
          zero_run++;
        end
      end
      prev_ena = ena;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single requester 0 for three cycles, then TURN and IDLE.
    do_reset();
    expect_grant(2'd0, 3, 1'b0);
    step(4'b0001, 3);
    step(4'b0000, 4);

    // All requesting: full-length rotation 0,1,2,3,0 with timeout each handover.
    do_reset();
    expect_grant(2'd0, 8, 1'b1);
    expect_grant(2'd1, 8, 1'b1);
    expect_grant(2'd2, 8, 1'b1);
    expect_grant(2'd3, 8, 1'b1);
    expect_grant(2'd0, 8, 1'b1);
    step(4'b1111, 45);
    step(4'b0000, 3);

    // Owner 2 is not preempted; afterwards 3 then 0.
    do_reset();
    expect_grant(2'd2, 5, 1'b0);
    expect_grant(2'd3, 3, 1'b0);
    expect_grant(2'd0, 2, 1'b0);
    step(4'b0100, 3);
    step(4'b1101, 2);
    step(4'b1001, 4);
    step(4'b0001, 3);
    step(4'b0000, 3);

    // Lone requester 1 is regranted through TURN; two timeouts in 20 cycles.
    do_reset();
    expect_grant(2'd1, 8, 1'b1);
    expect_grant(2'd1, 8, 1'b1);
    expect_grant(2'd1, 2, 1'b0);
    step(4'b0010, 20);
    step(4'b0000, 3);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    step(4'b0001, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ena", 32'(ena), 32'h0);
    chk("async_rst_vld", 32'(owner_vld), 32'h0);
    chk("async_rst_owner", 32'(owner), 32'h0);
    req = 4'b0110;
    repeat (2) @(posedge clk);
    #1;
    expect_grant(2'd1, 3, 1'b0);
    rst_n = 1'b1;
    step(4'b0110, 3);
    step(4'b0000, 4);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
